// File: rtl/avalon_cmd_master.sv
// Avalon-MM host: runs one single-beat read or write per command and returns one response.
// Requests are asserted the cycle after acceptance, so a write takes 3 cycles and a read 3+READ_LATENCY.
module avalon_cmd_master #(
    parameter int unsigned ADDR_W       = 4,
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned TIMEOUT      = 255
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,

    output logic              rsp_valid,
    output logic              rsp_write,
    output logic              rsp_err,
    output logic [DATA_W-1:0] rsp_data,

    output logic [ADDR_W-1:0] avm_m0_address,
    output logic [DATA_W-1:0] avm_m0_writedata,
    output logic              avm_m0_write,
    output logic              avm_m0_read,
    input  logic [DATA_W-1:0] avm_m0_readdata,
    input  logic              avm_m0_waitrequest,

    output logic              busy
);

    localparam int unsigned LAT_W = 3;
    localparam int unsigned TO_W  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam bit          TO_EN = (TIMEOUT != 0);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_EN ? TIMEOUT - 1 : 0);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        RD_REQ  = 3'd2,
        RD_WAIT = 3'd3,
        RESP    = 3'd4
    } state_t;

    state_t            state;
    logic [LAT_W-1:0]  lat_cnt;
    logic [TO_W-1:0]   to_cnt;
    logic              timeout_hit;

    // Current edge is a stalled edge that brings the stall count up to TIMEOUT.
    assign timeout_hit = TO_EN && avm_m0_waitrequest && (to_cnt == TO_LAST);

    assign cmd_ready = rst && (state == IDLE);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state            <= IDLE;
            lat_cnt          <= '0;
            to_cnt           <= '0;
            avm_m0_address   <= '0;
            avm_m0_writedata <= '0;
            avm_m0_write     <= 1'b0;
            avm_m0_read      <= 1'b0;
            rsp_valid        <= 1'b0;
            rsp_write        <= 1'b0;
            rsp_err          <= 1'b0;
            rsp_data         <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        avm_m0_address   <= cmd_addr;
                        avm_m0_writedata <= cmd_wdata;
                        to_cnt           <= '0;
                        state            <= cmd_write ? WR_REQ : RD_REQ;
                    end
                end

                WR_REQ: begin
                    if (!avm_m0_write) begin
                        avm_m0_write <= 1'b1;
                    end else if (!avm_m0_waitrequest || timeout_hit) begin
                        // waitrequest low wins over a coincident timeout
                        avm_m0_write <= 1'b0;
                        rsp_valid    <= 1'b1;
                        rsp_write    <= 1'b1;
                        rsp_err      <= avm_m0_waitrequest;
                        rsp_data     <= '0;
                        state        <= RESP;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end

                RD_REQ: begin
                    if (!avm_m0_read) begin
                        avm_m0_read <= 1'b1;
                    end else if (!avm_m0_waitrequest) begin
                        avm_m0_read <= 1'b0;
                        lat_cnt     <= LAT_W'(READ_LATENCY);
                        state       <= RD_WAIT;
                    end else if (timeout_hit) begin
                        avm_m0_read <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_write   <= 1'b0;
                        rsp_err     <= 1'b1;
                        rsp_data    <= '0;
                        state       <= RESP;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end

                RD_WAIT: begin
                    lat_cnt <= lat_cnt - LAT_W'(1);
                    if (lat_cnt == LAT_W'(1)) begin
                        rsp_valid <= 1'b1;
                        rsp_write <= 1'b0;
                        rsp_err   <= 1'b0;
                        rsp_data  <= avm_m0_readdata;
                        state     <= RESP;
                    end
                end

                RESP: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
